// File: rtl/gray_to_rgb565.sv
// gray_to_rgb565: expands a 12-bit weighted grayscale sample (R*14+G*46+B*5,
// max 3487) back into RGB565 through a two-stage valid/ready pipeline.
// Stage 1 normalises the sample to a 6-bit level. Stage 2 maps that level
// to RED/GREEN/BLUE and holds the result for the downstream handshake.
// A free-running counter tracks how many pixels have been delivered.
// Optional build macro: GRAY_FALSECOLOR_EN selects a heat-map colouring in
// stage 2 instead of gray replication. Latency and handshake do not change.
module gray_to_rgb565 #(
  parameter int GRAY_MAX    = 3487,
  parameter int SCALE_MULT  = 75,
  parameter int SCALE_SHIFT = 12,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [11:0]      GRAYSCALE,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [4:0]       RED,
  output logic [5:0]       GREEN,
  output logic [4:0]       BLUE,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] pix_count
);

  logic        w_s1_load;
  logic        w_s2_load;
  logic        w_deliver;
  logic [11:0] w_gray_sat;
  logic [18:0] w_prod;
  logic [18:0] w_shifted;
  logic [5:0]  w_level;
  logic [4:0]  w_red;
  logic [5:0]  w_green;
  logic [4:0]  w_blue;

  logic        r_s1_valid;
  logic [5:0]  r_s1_level;

  // Stage 2 takes a new sample when it is empty or its content leaves this
  // cycle. Stage 1 can take one when it is empty or drains into stage 2.
  assign w_s2_load = r_s1_valid && (!valid_out || ready_in);
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign ready_out = w_s1_load;
  assign w_deliver = valid_out && ready_in;

  // Normalise the grayscale sample to a 6-bit level, saturating out-of-range inputs
  always_comb begin
    if (GRAYSCALE > 12'(GRAY_MAX)) begin
      w_gray_sat = 12'(GRAY_MAX);
    end else begin
      w_gray_sat = GRAYSCALE;
    end
    w_prod    = 19'(w_gray_sat) * 19'(SCALE_MULT);
    w_shifted = w_prod >> SCALE_SHIFT;
    if (w_shifted > 19'd63) begin
      w_level = 6'd63;
    end else begin
      w_level = w_shifted[5:0];
    end
  end

  // Map the stage-1 level to RGB565 channels
  always_comb begin
`ifdef GRAY_FALSECOLOR_EN
    if (r_s1_level < 6'd32) begin
      // Cold half: blue fades out while green ramps up
      w_red   = 5'd0;
      w_green = {r_s1_level[4:0], 1'b0};
      w_blue  = 5'd31 - r_s1_level[4:0];
    end else begin
      // Hot half: L-32 is the low five bits, 63-L is their complement
      w_red   = r_s1_level[4:0];
      w_green = {~r_s1_level[4:0], 1'b1};
      w_blue  = 5'd0;
    end
`else
    w_red   = r_s1_level[5:1];
    w_green = r_s1_level;
    w_blue  = r_s1_level[5:1];
`endif
  end

  // Stage 1 register: captures the normalised level on every load slot
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_s1_valid <= 1'b0;
      r_s1_level <= 6'd0;
    end else if (w_s1_load) begin
      r_s1_valid <= valid_in;
      r_s1_level <= w_level;
    end else begin
      r_s1_valid <= r_s1_valid;
      r_s1_level <= r_s1_level;
    end
  end

  // Stage 2 register: output pixel and valid, frozen while downstream stalls
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_out <= 1'b0;
      RED       <= 5'd0;
      GREEN     <= 6'd0;
      BLUE      <= 5'd0;
    end else if (w_s2_load) begin
      valid_out <= 1'b1;
      RED       <= w_red;
      GREEN     <= w_green;
      BLUE      <= w_blue;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_out;
    end
  end

  // Delivered-pixel counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pix_count <= {CNT_W{1'b0}};
    end else if (w_deliver) begin
      pix_count <= pix_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pix_count <= pix_count;
    end
  end

endmodule

// File: tb/tb_gray_to_rgb565.sv
// Self-checking bench for gray_to_rgb565: table-driven directed vectors,
// stall / reset / streaming sequences and randomized traffic checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_gray_to_rgb565;

  logic        clk = 1'b0;
  logic        areset;
  logic [11:0] GRAYSCALE;
  logic        valid_in;
  logic        ready_in;
  logic        ready_out;
  logic [4:0]  RED;
  logic [5:0]  GREEN;
  logic [4:0]  BLUE;
  logic        valid_out;
  logic [31:0] pix_count;

  gray_to_rgb565 dut (
    .clk       (clk),
    .areset    (areset),
    .GRAYSCALE (GRAYSCALE),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gray;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp_count = 32'd0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_pix = 16'd0;
  int          deliveries = 0;
  int          ro_low = 0;

  // Reference: level = floor(min(g,3487)*75/4096) capped at 63, then colour map
  function automatic logic [15:0] model(input int g);
    int gs, l, r, gg, b;
    gs = (g > 3487) ? 3487 : g;
    l  = (gs * 75) / 4096;
    if (l > 63) l = 63;
`ifdef GRAY_FALSECOLOR_EN
    if (l < 32) begin
      r = 0; gg = 2 * l; b = 31 - l;
    end else begin
      r = l - 32; gg = 2 * (63 - l) + 1; b = 0;
    end
`else
    r = l / 2; gg = l; b = l / 2;
`endif
    return {5'(r), 6'(gg), 5'(b)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: inputs were set at the preceding negedge; judge the handshake,
  // update the scoreboard, then move to the next negedge.
  task automatic step(output logic acc);
    logic del;
    #1;
    chk("ready_out", ready_out, (exp_q.size() == 2 && !ready_in) ? 0 : 1);
    if (!ready_out) ro_low++;
    if (prev_stall) begin
      chk("stall_valid", valid_out, 1);
      chk("stall_hold", {RED, GREEN, BLUE}, prev_pix);
    end
    acc = valid_in && ready_out;
    del = valid_out && ready_in;
    if (valid_out && exp_q.size() == 0) chk("spurious_out", valid_out, 0);
    if (del && exp_q.size() > 0) begin
      chk("pixel", {RED, GREEN, BLUE}, exp_q.pop_front());
      exp_count = exp_count + 32'd1;
      deliveries++;
    end
    prev_stall = valid_out && !ready_in;
    prev_pix   = {RED, GREEN, BLUE};
    if (acc) exp_q.push_back(model(int'(GRAYSCALE)));
    @(negedge clk);
    chk("pix_count", pix_count, exp_count);
  endtask

  task automatic drain();
    logic a;
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || valid_out); i++) step(a);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic        a;
    int          idx, base_del, bubbles;
    logic [31:0] base_cnt;

`ifdef GRAY_FALSECOLOR_EN
    vecs[0] = '{0,    5'd0,  6'd0,  5'd31};
    vecs[1] = '{1744, 5'd0,  6'd62, 5'd0};
    vecs[2] = '{3487, 5'd31, 6'd1,  5'd0};
    vecs[3] = '{4095, 5'd31, 6'd1,  5'd0};
    vecs[4] = '{55,   5'd0,  6'd2,  5'd30};
    vecs[5] = '{2000, 5'd4,  6'd55, 5'd0};
`else
    vecs[0] = '{0,    5'd0,  6'd0,  5'd0};
    vecs[1] = '{1744, 5'd15, 6'd31, 5'd15};
    vecs[2] = '{3487, 5'd31, 6'd63, 5'd31};
    vecs[3] = '{4095, 5'd31, 6'd63, 5'd31};
    vecs[4] = '{55,   5'd0,  6'd1,  5'd0};
    vecs[5] = '{2000, 5'd18, 6'd36, 5'd18};
`endif

    // Reset state
    areset = 1'b1; GRAYSCALE = 12'd0; valid_in = 1'b0; ready_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_rgb", {RED, GREEN, BLUE}, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_ready_out", ready_out, 1);
    areset = 1'b0;

    // Directed vectors: two-cycle latency and exact colour values
    foreach (vecs[i]) begin
      GRAYSCALE = 12'(vecs[i].gray); valid_in = 1'b1; ready_in = 1'b1;
      step(a);
      chk("lat_not_yet", valid_out, 0);
      valid_in = 1'b0;
      step(a);
      chk("lat_valid", valid_out, 1);
      chk($sformatf("vec_%0d_rgb", vecs[i].gray), {RED, GREEN, BLUE},
          {vecs[i].r, vecs[i].g, vecs[i].b});
      step(a);
    end
    chk("vec_pix_count", pix_count, 6);

    // Eight samples with downstream stalled for cycles 3-6
    base_del = deliveries; base_cnt = pix_count; ro_low = 0; idx = 0;
    for (int c = 0; c < 60 && (idx < 8 || exp_q.size() > 0); c++) begin
      valid_in  = (idx < 8);
      GRAYSCALE = 12'(idx * 500);
      ready_in  = !(c >= 3 && c <= 6);
      step(a);
      if (a) idx++;
    end
    chk("stall_backpressure", ro_low > 0, 1);
    chk("stall_delivered", deliveries - base_del, 8);
    chk("stall_pix_count", pix_count - base_cnt, 8);
    drain();

    // Continuous stream: no bubbles after the two-cycle fill
    bubbles = 0; base_del = deliveries; ready_in = 1'b1;
    for (int c = 0; c < 22; c++) begin
      valid_in  = (c < 20);
      GRAYSCALE = 12'($urandom_range(0, 4095));
      if (c >= 2 && !valid_out) bubbles++;
      step(a);
    end
    chk("stream_bubbles", bubbles, 0);
    chk("stream_delivered", deliveries - base_del, 20);
    drain();

    // Randomized traffic, biased toward the saturation boundary now and then
    for (int c = 0; c < 400; c++) begin
      valid_in = 1'($urandom_range(0, 1));
      ready_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       GRAYSCALE = 12'($urandom_range(3480, 3495));
        default: GRAYSCALE = 12'($urandom_range(0, 4095));
      endcase
      step(a);
    end
    drain();

    // Reset with both stages full: immediate clear, no stale output afterwards
    ready_in = 1'b0; valid_in = 1'b1; GRAYSCALE = 12'd3000;
    repeat (3) step(a);
    chk("full_before_rst", valid_out && !ready_out, 1);
    #2 areset = 1'b1;
    #1;
    chk("async_valid_out", valid_out, 0);
    chk("async_pix_count", pix_count, 0);
    chk("async_rgb", {RED, GREEN, BLUE}, 0);
    chk("async_ready_out", ready_out, 1);
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b1;
    exp_q.delete(); exp_count = 32'd0; prev_stall = 1'b0;
    areset = 1'b0;
    repeat (5) step(a);
    chk("post_rst_idle", valid_out, 0);
    GRAYSCALE = 12'd1744; valid_in = 1'b1;
    step(a);
    drain();
    chk("post_rst_pix_count", pix_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gray_to_rgb565.md
Name: gray_to_rgb565

Overview:
- Inverse of the grayscale path: expands a 12-bit weighted-sum grayscale sample back to RGB565 for the VGA/LCD display buffer.
- Used to overlay tracking results on a grayscale preview.
- Two-stage elastic pipeline with a valid/ready handshake on both sides, plus a delivered-pixel counter for debug.
- Input scale matches the grayscale producer: R*14 + G*46 + B*5, maximum 3487.

Parameters:
- GRAY_MAX, 3487: largest legal input value; inputs above it saturate.
- SCALE_MULT, 75: multiplier for normalising GRAYSCALE to a 6-bit level.
- SCALE_SHIFT, 12: right shift applied after SCALE_MULT.
- CNT_W, 32: width of the pixel counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- areset  in  1  asynchronous reset, active-high.
- GRAYSCALE  in  12  grayscale sample.
- valid_in  in  1  GRAYSCALE valid.
- ready_out  out  1  block can accept a sample this cycle.
- RED  out  5  red channel.
- GREEN  out  6  green channel.
- BLUE  out  5  blue channel.
- valid_out  out  1  RED/GREEN/BLUE valid.
- ready_in  in  1  downstream accepts this cycle.
- pix_count  out  CNT_W  number of pixels delivered (valid_out && ready_in).

Behaviour:
- Reset: areset high clears RED, GREEN, BLUE, valid_out, pix_count and both internal valid flags to 0 immediately, without waiting for a clock edge.
  - ready_out = 1 while in reset.
  - Reset asserted mid-stream discards all in-flight samples; no output follows reset release until new input arrives.
- Transfers: input accepted when valid_in && ready_out; output delivered when valid_out && ready_in.
- Stage 1 (s1):
  - p = GRAYSCALE*SCALE_MULT, 19-bit unsigned.
  - level = p >> SCALE_SHIFT, clamped to 63. GRAY_MAX maps to 63; any input > GRAY_MAX gives 63.
  - Registers level[5:0] and s1_valid.
- Stage 2 (s2): RED = level[5:1], GREEN = level, BLUE = level[5:1]. Registers the outputs and valid_out.
- Advance rules:
  - s2_load = s1_valid && (!valid_out || ready_in).
  - s1_load = !s1_valid || s2_load.
  - ready_out = s1_load (combinational from ready_in; this path is accepted).
- s1_valid next value:
  - s1_load: becomes valid_in.
  - otherwise: holds.
- valid_out next value:
  - s2_load: set to 1.
  - else, if ready_in: clears to 0.
- Latency: 2 cycles from accept to valid_out with no stall. Full throughput of 1 pixel/cycle when ready_in is held high.
- Stall: while valid_out && !ready_in, RED/GREEN/BLUE/valid_out hold stable. s1 holds one further sample, so 2 samples are buffered. ready_out deasserts only when both stages are full and ready_in is low.
- Simultaneous accept and deliver in the same cycle: both occur and no sample is lost.
- Sample order is preserved; no duplication.
- pix_count increments by 1 on each delivery and wraps at 2^CNT_W to 0.

Optional Feature:
- Macro: GRAY_FALSECOLOR_EN.
- Defined: stage 2 applies a heat map instead of gray replication, using level L:
  - L<32: RED=0, GREEN=2L, BLUE=31-L.
  - L>=32: RED=L-32, GREEN=2*(63-L)+1, BLUE=0.
- Latency and handshake are unchanged.
- Undefined: gray replication as described in Behaviour.

Test Plan:
- Reset, then GRAYSCALE=0 with valid_in=1 and ready_in=1 -> after 2 cycles RED=0, GREEN=0, BLUE=0, valid_out=1, pix_count=1.
- GRAYSCALE=1744 -> level 31 -> RED=15, GREEN=31, BLUE=15. GRAYSCALE=3487 -> RED=31, GREEN=63, BLUE=31.
- GRAYSCALE=4095 -> saturates to RED=31, GREEN=63, BLUE=31. With GRAY_FALSECOLOR_EN: 4095 -> RED=31, GREEN=1, BLUE=0, and 0 -> RED=0, GREEN=0, BLUE=31.
- Stream 8 samples 0,500,...,3500 with ready_in low for cycles 3-6:
  - ready_out falls once 2 samples are buffered.
  - Outputs stay stable during the stall.
  - All 8 delivered in order; pix_count=8.
- Continuous stream with ready_in=1 -> one output per cycle after a 2-cycle fill, no bubbles.
- Assert areset for 1 cycle with both stages full -> valid_out drops without waiting for a clock edge; no stale pixel after release; pix_count=0.
